// File: rtl/arm_seq_ctrl_pkg.sv
// rtl/arm_seq_ctrl_pkg.sv - state, class and mux-select encodings for the ARM control sequencer
package arm_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        CLS_DP    = 2'd0,
        CLS_LS    = 2'd1,
        CLS_BR    = 2'd2,
        CLS_UNDEF = 2'd3
    } inst_class_t;

    localparam logic [1:0] WB_SEL_ALU    = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD   = 2'd1;
    localparam logic [1:0] WB_SEL_LINK   = 2'd2;

    localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_ALU    = 2'd2;

    // Takes ir[27:25]; 100 (block transfer) and 11x (coprocessor/SWI) fall to UNDEF.
    function automatic inst_class_t decode_class(input logic [2:0] op);
        inst_class_t cls;
        if (op[2:1] == 2'b00)
            cls = CLS_DP;
        else if (op[2:1] == 2'b01)
            cls = CLS_LS;
        else if (op == 3'b101)
            cls = CLS_BR;
        else
            cls = CLS_UNDEF;
        return cls;
    endfunction

endpackage

// File: rtl/arm_mem_wait_timer.sv
// rtl/arm_mem_wait_timer.sv - per-access memory wait counter with timeout compare
module arm_mem_wait_timer #(
    parameter int WAIT_MAX = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic active,
    input  logic ack,
    output logic timeout
);

    localparam int W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [W-1:0] LIMIT = W'(WAIT_MAX);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear || (active && ack))
            count <= '0;
        else if (active && count != LIMIT)
            count <= count + 1'b1;
    end

    // An ack in the limit cycle beats the timeout.
    assign timeout = active && !ack && (count == LIMIT);

endmodule

// File: rtl/arm_seq_ctrl.sv
// rtl/arm_seq_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer
module arm_seq_ctrl
    import arm_seq_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      ir,
    input  logic             cond_pass,
    output logic             rd_we,
    output logic [1:0]       wb_sel,
    output logic             link_sel,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             cpsr_we,
    output logic             fault,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] inst_count
);

    state_t            state, next_state;
    inst_class_t       cls;
    logic [31:0]       ir_q;
    logic              cond_ok;
    logic              fault_q;
    logic [CNT_W-1:0]  count_q;
    logic              req_cycle;
    logic              timer_clear;
    logic              timeout;

    assign cls       = decode_class(ir_q[27:25]);
    assign req_cycle = (state == ST_FETCH && !stall) || (state == ST_MEM);
    assign timer_clear = (next_state == ST_FETCH && state != ST_FETCH) ||
                         (next_state == ST_MEM   && state != ST_MEM);

    arm_mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .active  (req_cycle),
        .ack     (mem_ack),
        .timeout (timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_FETCH;
            ir_q    <= '0;
            cond_ok <= 1'b0;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            state <= next_state;
            if (state == ST_FETCH && !stall && mem_ack)
                ir_q <= mem_rdata;
            if (state == ST_EXEC)
                cond_ok <= cond_pass;
            if (next_state == ST_FAULT && state != ST_FAULT)
                fault_q <= 1'b1;
            if (state == ST_WB)
                count_q <= count_q + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_FETCH: begin
                if (!stall) begin
                    if (mem_ack)
                        next_state = ST_DECODE;
                    else if (timeout)
                        next_state = ST_FAULT;
                end
            end
            ST_DECODE: next_state = ST_EXEC;
            ST_EXEC:   next_state = (cond_pass && cls == CLS_LS) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (mem_ack)
                    next_state = ST_WB;
                else if (timeout)
                    next_state = ST_FAULT;
            end
            ST_WB:     next_state = ST_FETCH;
            ST_FAULT:  next_state = ST_FAULT;
            default:   next_state = ST_FETCH;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        rd_we    = 1'b0;
        wb_sel   = WB_SEL_ALU;
        link_sel = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = PC_SEL_SEQ;
        cpsr_we  = 1'b0;
        case (state)
            // rst_n gating drops the fetch request the instant reset asserts.
            ST_FETCH: mem_req = rst_n && !stall;
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = !ir_q[20];
            end
            ST_WB: begin
                pc_we = 1'b1;
                if (cond_ok) begin
                    case (cls)
                        CLS_DP: begin
                            cpsr_we = ir_q[20];
                            if (ir_q[24:23] == 2'b10)
                                rd_we = 1'b0;
                            else if (ir_q[15:12] == 4'hF)
                                pc_sel = PC_SEL_ALU;
                            else
                                rd_we = 1'b1;
                        end
                        CLS_LS: begin
                            if (ir_q[20]) begin
                                rd_we  = 1'b1;
                                wb_sel = WB_SEL_LOAD;
                            end
                        end
                        CLS_BR: begin
                            pc_sel = PC_SEL_BRANCH;
                            if (ir_q[24]) begin
                                rd_we    = 1'b1;
                                wb_sel   = WB_SEL_LINK;
                                link_sel = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    assign ir         = ir_q;
    assign fault      = fault_q;
    assign state_o    = state;
    assign inst_count = count_q;

endmodule

// File: tb/tb_arm_seq_ctrl.sv
// tb/tb_arm_seq_ctrl.sv - directed table-driven bench for arm_seq_ctrl
module tb_arm_seq_ctrl;

    localparam int WAIT_MAX = 4;
    localparam int CNT_W    = 3;

    logic             clk;
    logic             rst_n;
    logic             stall;
    logic             mem_req;
    logic             mem_we;
    logic             addr_sel;
    logic             mem_ack;
    logic [31:0]      mem_rdata;
    logic [31:0]      ir;
    logic             cond_pass;
    logic             rd_we;
    logic [1:0]       wb_sel;
    logic             link_sel;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             cpsr_we;
    logic             fault;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] inst_count;

    arm_seq_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .addr_sel   (addr_sel),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .ir         (ir),
        .cond_pass  (cond_pass),
        .rd_we      (rd_we),
        .wb_sel     (wb_sel),
        .link_sel   (link_sel),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .cpsr_we    (cpsr_we),
        .fault      (fault),
        .state_o    (state_o),
        .inst_count (inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {rd_we, pc_we, cpsr_we, link_sel, wb_sel[1:0], pc_sel[1:0]}
    logic [7:0] strb;
    assign strb = {rd_we, pc_we, cpsr_we, link_sel, wb_sel, pc_sel};

    typedef struct {
        logic [31:0] inst;
        logic        cp;
        logic        goes_mem;
        int          mem_wait;
        logic        exp_mem_we;
        logic [7:0]  exp_strb;
    } vec_t;

    vec_t             vecs[12];
    int               n_checks;
    int               n_fail;
    logic [CNT_W-1:0] exp_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        stall     = 1'b0;
        cond_pass = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = v.inst;
        #1;
        check($sformatf("v%0d fetch_state", idx), 32'(state_o), 32'd0);
        check($sformatf("v%0d fetch_bus", idx), {29'd0, mem_req, addr_sel, mem_we}, 32'b100);
        tick();
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        check($sformatf("v%0d decode_state", idx), 32'(state_o), 32'd1);
        check($sformatf("v%0d decode_quiet", idx), {23'd0, mem_req, strb}, 32'd0);
        check($sformatf("v%0d ir", idx), ir, v.inst);
        tick();
        cond_pass = v.cp;
        #1;
        check($sformatf("v%0d exec_state", idx), 32'(state_o), 32'd2);
        check($sformatf("v%0d exec_quiet", idx), {23'd0, mem_req, strb}, 32'd0);
        tick();
        cond_pass = 1'b0;
        if (v.goes_mem) begin
            for (int d = 0; d <= v.mem_wait; d++) begin
                mem_ack = (d == v.mem_wait);
                #1;
                check($sformatf("v%0d mem_state", idx), 32'(state_o), 32'd3);
                check($sformatf("v%0d mem_bus", idx),
                      {21'd0, mem_req, addr_sel, mem_we, strb}, {21'd0, 1'b1, 1'b1, v.exp_mem_we, 8'd0});
                tick();
            end
        end
        mem_ack = 1'b0;
        #1;
        check($sformatf("v%0d wb_state", idx), 32'(state_o), 32'd4);
        check($sformatf("v%0d wb_strobes", idx), {24'd0, strb}, {24'd0, v.exp_strb});
        check($sformatf("v%0d wb_nofault", idx), {30'd0, fault, mem_req}, 32'd0);
        tick();
        exp_cnt = exp_cnt + 1'b1;
        #1;
        check($sformatf("v%0d inst_count", idx), 32'(inst_count), 32'(exp_cnt));
        check($sformatf("v%0d back_to_fetch", idx), 32'(state_o), 32'd0);
        check($sformatf("v%0d post_wb_quiet", idx), {24'd0, strb}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_cnt   = '0;
        rst_n     = 1'b0;
        stall     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        cond_pass = 1'b0;

        vecs[0]  = '{32'hE082_1003, 1'b1, 1'b0, 0, 1'b0, 8'b1100_0000};  // ADD r1,r2,r3
        vecs[1]  = '{32'hE591_2000, 1'b1, 1'b1, 3, 1'b0, 8'b1100_0100};  // LDR, 3 waits
        vecs[2]  = '{32'h0082_1003, 1'b0, 1'b0, 0, 1'b0, 8'b0100_0000};  // ADDEQ, cond fails
        vecs[3]  = '{32'hEB00_0010, 1'b1, 1'b0, 0, 1'b0, 8'b1101_1001};  // BL
        vecs[4]  = '{32'hE151_0002, 1'b1, 1'b0, 0, 1'b0, 8'b0110_0000};  // CMP
        vecs[5]  = '{32'hE1B0_F00E, 1'b1, 1'b0, 0, 1'b0, 8'b0110_0010};  // MOVS pc,lr
        vecs[6]  = '{32'hE581_2000, 1'b1, 1'b1, 0, 1'b1, 8'b0100_0000};  // STR
        vecs[7]  = '{32'hEA00_0004, 1'b1, 1'b0, 0, 1'b0, 8'b0100_0001};  // B
        vecs[8]  = '{32'hEE00_0000, 1'b1, 1'b0, 0, 1'b0, 8'b0100_0000};  // UNDEF
        vecs[9]  = '{32'h1591_2000, 1'b0, 1'b0, 0, 1'b0, 8'b0100_0000};  // LDRNE, cond fails
        vecs[10] = '{32'hE092_1003, 1'b1, 1'b0, 0, 1'b0, 8'b1110_0000};  // ADDS
        vecs[11] = '{32'hE591_2000, 1'b1, 1'b1, WAIT_MAX, 1'b0, 8'b1100_0100};  // ack at limit

        #1;
        check("reset_state", 32'(state_o), 32'd0);
        check("reset_outputs", {20'd0, mem_req, mem_we, addr_sel, fault, strb}, 32'd0);
        check("reset_ir", ir, 32'd0);
        check("reset_count", 32'(inst_count), 32'd0);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            run_vec(i, vecs[i]);

        // Reset asserted while a load waits in MEM.
        mem_ack   = 1'b1;
        mem_rdata = 32'hE591_2000;
        tick();
        mem_ack = 1'b0;
        tick();
        cond_pass = 1'b1;
        tick();
        cond_pass = 1'b0;
        #1;
        check("midmem_state", 32'(state_o), 32'd3);
        check("midmem_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midmem_reset_state", 32'(state_o), 32'd0);
        check("midmem_reset_outputs", {20'd0, mem_req, mem_we, addr_sel, fault, strb}, 32'd0);
        check("midmem_reset_ir", ir, 32'd0);
        check("midmem_reset_count", 32'(inst_count), 32'd0);
        exp_cnt = '0;
        tick();
        rst_n = 1'b1;
        run_vec(100, vecs[0]);

        // Stalled FETCH ignores ack and issues no request.
        stall   = 1'b1;
        mem_ack = 1'b1;
        for (int s = 0; s < 2; s++) begin
            #1;
            check("stall_no_req", {30'd0, mem_req, state_o == 3'd0}, 32'b01);
            tick();
        end
        stall   = 1'b0;
        mem_ack = 1'b0;
        for (int d = 0; d <= WAIT_MAX; d++) begin
            #1;
            check("timeout_pending", {29'd0, mem_req, fault, state_o == 3'd0}, 32'b101);
            tick();
        end
        #1;
        check("fault_state", 32'(state_o), 32'd7);
        check("fault_outputs", {22'd0, mem_req, fault, strb}, {22'd0, 1'b0, 1'b1, 8'd0});
        mem_ack = 1'b1;
        tick();
        #1;
        check("fault_ignores_ack", {28'd0, state_o, fault}, {28'd0, 3'd7, 1'b1});
        mem_ack = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("fault_cleared", {28'd0, state_o, fault}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arm_seq_ctrl.md
Name: arm_seq_ctrl

Overview:
- Multi-cycle control sequencer for the single-issue ARM core.
- Owns the instruction register, the shared memory port handshake and all architectural write strobes (rd_we, pc_we, cpsr_we).
- Sequences the decoder, barrel-shifter and ALU datapath through the FETCH/DECODE/EXEC/MEM/WB states.
- Sits between the memory interface and arm_decode; also drives the cond_checker and the register file.

Parameters:
- WAIT_MAX, 255: memory wait cycles allowed per access before a bus fault.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  holds sequencer in FETCH before issuing a request
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = store
- addr_sel  out  1  0 = PC, 1 = ALU result drives mem address
- mem_ack  in  1  access complete; rdata valid this cycle
- mem_rdata  in  32  read data
- ir  out  32  instruction register, feeds arm_decode inst
- cond_pass  in  1  from cond_checker, valid in EXEC
- rd_we  out  1  register-file write strobe
- wb_sel  out  2  0 = ALU, 1 = load data, 2 = PC+4 (link)
- link_sel  out  1  forces write address to r14
- pc_we  out  1  PC write strobe
- pc_sel  out  2  0 = PC+4, 1 = branch target, 2 = ALU result
- cpsr_we  out  1  flag update strobe
- fault  out  1  sticky bus-timeout flag
- state_o  out  3  current state, for debug
- inst_count  out  CNT_W  retired instructions

Behaviour:
- Reset (async, rst_n low):
  - state = FETCH; ir = 0; fault = 0; inst_count = 0; wait counter = 0.
  - All strobes, mem_req, mem_we and addr_sel are 0; wb_sel, pc_sel and link_sel are 0.
  - Reset asserted mid-access drops mem_req immediately, with no completion.
- Class decode from ir[27:25]:
  - DP: 00x.
  - LS: 01x (load if ir[20]).
  - BR: 101 (link if ir[24]).
  - Anything else is UNDEF, treated as a NOP that still advances the PC.
- FETCH:
  - If stall, stay with mem_req = 0.
  - Otherwise mem_req = 1, addr_sel = 0, mem_we = 0.
  - On mem_ack, latch ir = mem_rdata and go to DECODE. An ack in the first request cycle is legal (zero-wait).
- DECODE: 1 cycle with no strobes; register-file reads settle. Go to EXEC.
- EXEC: 1 cycle; ALU and shifter results settle.
  - If cond_pass = 0, go to WB with only pc_we / pc_sel = 0.
  - Else LS goes to MEM; all others go to WB.
- MEM:
  - mem_req = 1, addr_sel = 1, mem_we = !ir[20].
  - On mem_ack: a load captures rdata for WB. Go to WB.
- WB: 1 cycle. pc_we = 1 in every case. Strobes by class:
  - DP: cpsr_we = ir[20].
    - If opcode is 10xx (TST/TEQ/CMP/CMN): rd_we = 0.
    - Else if rd = 15: rd_we = 0, pc_sel = 2.
    - Else rd_we = 1, wb_sel = 0, pc_sel = 0.
  - LS load: rd_we = 1, wb_sel = 1, pc_sel = 0. Store: rd_we = 0.
  - BR: pc_sel = 1. If link: rd_we = 1, wb_sel = 2, link_sel = 1.
  - Condition-failed or UNDEF: pc_sel = 0 only.
  - inst_count += 1, wrapping at 2^CNT_W-1 to 0. Then go to FETCH.
- Wait counter:
  - Cleared on entry to FETCH or MEM and on ack; increments each request cycle without ack.
  - When count reaches WAIT_MAX with no ack: drop mem_req, set fault = 1, enter FAULT.
  - An ack in the same cycle as count = WAIT_MAX wins; no fault.
- FAULT: all strobes and mem_req are 0. Exit only via reset.
- mem_ack outside a request cycle is ignored.
- All strobes are single-cycle pulses.
- Latency: 4 cycles for a zero-wait non-LS instruction; 5 cycles for LS.

Decomposition:
- Add to arm_defines.vh:
  - State encodings FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, FAULT = 7.
  - Class codes, WB_SEL_* and PC_SEL_* constants.
- One natural sub-module, arm_mem_wait_timer: wait counter and timeout compare, reused for both FETCH and MEM accesses.

Test Plan:
- Zero-wait ADD r1,r2,r3 (0xE0821003), cond_pass = 1 → rd_we pulses exactly in cycle 4, wb_sel = 0, pc_we = 1 with pc_sel = 0, cpsr_we = 0, inst_count = 1.
- LDR with ack delayed 3 cycles in MEM (cond_pass = 1) → mem_req held, addr_sel = 1, mem_we = 0; WB has rd_we = 1 and wb_sel = 1; total 8 cycles.
- Conditional instruction with cond_pass = 0 → no rd_we or cpsr_we; pc_we = 1 with pc_sel = 0; inst_count still increments.
- BL (0xEB000010) → WB shows pc_sel = 1, rd_we = 1, wb_sel = 2, link_sel = 1.
- No ack during FETCH with WAIT_MAX = 4:
  - fault rises after 4 wait cycles, mem_req drops and state_o = 7.
  - An ack arriving afterwards is ignored.
  - rst_n low clears fault.
- CMP with S (0xE1510002) → cpsr_we = 1, rd_we = 0. MOVS pc,lr with rd = 15 → pc_sel = 2, rd_we = 0. Reset asserted mid-MEM → all outputs 0 immediately.
